// File: rtl/mult_pkg.sv
// Shared constants and FSM encoding for the multiplier arbiter.
package mult_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_MULT = 2'd2,
    DELIVER   = 2'd3
  } state_t;
endpackage

// File: rtl/asmd_mult.sv
// Sequential shift-add multiplier: one partial product per cycle, WIDTH cycles.
// o_ready is high whenever no product is being computed; o_r holds the last
// product until the next start.
module asmd_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_ready,
  output logic [2*WIDTH-1:0] o_r
);
  localparam int CW = $clog2(WIDTH + 1);

  logic               r_busy;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;

  // Load operands on start, then add-and-shift until the count runs out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start && !r_busy) begin
      r_busy   <= 1'b1;
      r_cnt    <= CW'(WIDTH);
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (r_busy) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

  assign o_ready = !r_busy;
  assign o_r     = r_acc;
endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among NUM_REQ
// requesters. Operands are captured at grant so the product in flight is
// immune to later input changes.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   a_in,
  input  logic [NUM_REQ*WIDTH-1:0]   b_in,
  output logic [NUM_REQ-1:0]         ack,
  output logic [2*WIDTH-1:0]         result,
  output logic [$clog2(NUM_REQ)-1:0] result_id,
  output logic                       busy
);
  localparam int IDW = $clog2(NUM_REQ);

  state_t             r_state;
  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     r_id;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_first;

  logic               w_found;
  logic [IDW-1:0]     w_grant;
  logic [IDW-1:0]     w_next_ptr;
  int                 w_idx;
  logic               w_start;
  logic               w_mready;
  logic [2*WIDTH-1:0] w_mr;

  // Search from rr_ptr upward with wrap; first active request wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_grant = IDW'(w_idx);
      end
    end
  end

  assign w_next_ptr = (w_grant == IDW'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;

  // Grant, issue, wait for the multiplier, deliver; operands latched at grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_first  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found && w_mready) begin
            r_id     <= w_grant;
            r_a      <= a_in[w_grant*WIDTH +: WIDTH];
            r_b      <= b_in[w_grant*WIDTH +: WIDTH];
            r_rr_ptr <= w_next_ptr;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_first <= 1'b1;
          r_state <= WAIT_MULT;
        end
        WAIT_MULT: begin
          // ready may still read as idle in the cycle right after start
          r_first <= 1'b0;
          if (!r_first && w_mready) r_state <= DELIVER;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_start = (r_state == ISSUE);

  asmd_mult #(.WIDTH(WIDTH)) u_asmd_mult (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_a     (r_a),
    .i_b     (r_b),
    .o_ready (w_mready),
    .o_r     (w_mr)
  );

  // Outputs are qualified by DELIVER so they read zero whenever ack is low.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      ack[i] = (r_state == DELIVER) && (r_id == IDW'(i));
    result    = (r_state == DELIVER) ? w_mr : '0;
    result_id = (r_state == DELIVER) ? r_id : '0;
  end

  assign busy = (r_state != IDLE);
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with hand-computed products and grant order.
module tb_mult_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a_in;
  logic [N*W-1:0]   b_in;
  logic [N-1:0]     ack;
  logic [2*W-1:0]   result;
  logic [1:0]       result_id;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0]   g_ack;
  logic [2*W-1:0] g_res;
  logic [1:0]     g_id;

  mult_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .result(result), .result_id(result_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    a_in[i*W +: W] = W'(a);
    b_in[i*W +: W] = W'(b);
  endtask

  // Sample at negedges until an ack shows up (bounded).
  task automatic wait_ack(input string tag);
    bit seen;
    seen  = 0;
    g_ack = '0; g_res = '0; g_id = '0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        seen  = 1;
        g_ack = ack; g_res = result; g_id = result_id;
      end
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic one_shot(input string tag, input int i, input int a, input int b,
                          input int exp_res);
    set_ops(i, a, b);
    req = N'(1) << i;
    wait_ack(tag);
    req = '0;
    chk({tag, "_ack"}, 32'(g_ack), 32'(N'(1) << i));
    chk({tag, "_res"}, 32'(g_res), 32'(exp_res));
    chk({tag, "_id"},  32'(g_id),  32'(i));
    @(negedge clk);
    chk({tag, "_ack1cyc"}, 32'(ack), 0);
    @(negedge clk);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    bit saw_ack;
    int k;
    rst = 1'b1; req = '0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_res", 32'(result), 0);
    chk("rst_id",  32'(result_id), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // single requester: 3 x 5
    one_shot("basic", 0, 3, 5, 15);

    // all four held after a fresh reset: grants start at 0 and rotate
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    for (int i = 0; i < N; i++) set_ops(i, i + 1, 2);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack("rr4");
      chk($sformatf("rr4_id%0d", n),  32'(g_id),  32'(n % N));
      chk($sformatf("rr4_res%0d", n), 32'(g_res), 32'(2 * ((n % N) + 1)));
      chk($sformatf("rr4_ack%0d", n), 32'(g_ack), 32'(N'(1) << (n % N)));
      if (n == 4) req = '0;
      @(negedge clk);
      chk($sformatf("rr4_pulse%0d", n), 32'(ack), 0);
    end
    repeat (2) @(negedge clk);

    one_shot("zero",  1, 0, 9, 0);
    one_shot("max",   2, 255, 255, 65025);

    // operand change after grant must not affect the product
    set_ops(1, 7, 6);
    req = 4'b0010;
    k = 0;
    while (!busy && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) chk("latch_grant_timeout", 0, 1);
    set_ops(1, 100, 6);
    wait_ack("latch");
    req = '0;
    chk("latch_res", 32'(g_res), 42);
    chk("latch_id",  32'(g_id), 1);
    repeat (2) @(negedge clk);

    // rr_ptr is now 2: pending 0,1,3 resolve as 3, 0, 1
    for (int i = 0; i < N; i++) set_ops(i, 10 + i, 3);
    req = 4'b1011;
    wait_ack("wrap0"); req[g_id] = 1'b0;
    chk("wrap0_id", 32'(g_id), 3); chk("wrap0_res", 32'(g_res), 39);
    wait_ack("wrap1"); req[g_id] = 1'b0;
    chk("wrap1_id", 32'(g_id), 0); chk("wrap1_res", 32'(g_res), 30);
    wait_ack("wrap2"); req[g_id] = 1'b0;
    chk("wrap2_id", 32'(g_id), 1); chk("wrap2_res", 32'(g_res), 33);
    repeat (2) @(negedge clk);

    // reset in the middle of WAIT_MULT abandons the op; req0 then completes
    set_ops(0, 9, 11);
    req = 4'b0001;
    k = 0;
    while (!busy && k < 50) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ack",  32'(ack), 0);
    chk("mid_rst_res",  32'(result), 0);
    chk("mid_rst_id",   32'(result_id), 0);
    saw_ack = 0;
    repeat (2) begin @(negedge clk); if (ack != '0) saw_ack = 1; end
    chk("mid_rst_noack", 32'(saw_ack), 0);
    rst = 1'b0;
    wait_ack("after_rst");
    req = '0;
    chk("after_rst_ack", 32'(g_ack), 1);
    chk("after_rst_res", 32'(g_res), 99);
    chk("after_rst_id",  32'(g_id), 0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one multiplier; legal range 2..8.
REQ-002 Parameter WIDTH, default 8: operand width; the result is 2*WIDTH bits.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset: clk is the only clock and rst the only reset.
REQ-004 Port clk  input  1: rising-edge clock for all state.
REQ-005 Port rst  input  1: asynchronous, active-high reset.
REQ-006 Port req  input  NUM_REQ: per-requester level request, held high until its ack.
REQ-007 Port a_in  input  NUM_REQ*WIDTH: packed multiplicands; slice i belongs to requester i.
REQ-008 Port b_in  input  NUM_REQ*WIDTH: packed multipliers; slice i belongs to requester i.
REQ-009 Port ack  output  NUM_REQ: one-hot, one-cycle completion pulse per requester.
REQ-010 Port result  output  2*WIDTH: product, valid in any cycle where ack is nonzero.
REQ-011 Port result_id  output  $clog2(NUM_REQ): index of the requester being acknowledged.
REQ-012 Port busy  output  1: high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, ISSUE, WAIT_MULT and DELIVER.
REQ-014 IDLE: when any req bit is high and the multiplier reports ready, the block SHALL register the winning index and operands, then move to ISSUE.
REQ-015 ISSUE: the block SHALL drive the multiplier start high for exactly one cycle with the latched operands, then move to WAIT_MULT.
REQ-016 WAIT_MULT: the block SHALL ignore the multiplier's ready in the first cycle after start; afterwards, ready=1 SHALL move the FSM to DELIVER.
REQ-017 DELIVER: the block SHALL assert ack[id] for one cycle, drive result with the multiplier output and result_id with the latched index, then return to IDLE.
REQ-018 Arbitration SHALL be round-robin: search starts at rr_ptr, and after each grant rr_ptr becomes (granted+1) mod NUM_REQ.
REQ-019 Simultaneous requests SHALL be resolved in a single IDLE cycle; losing requests stay pending with no loss.
REQ-020 A requester whose req stays high after its ack SHALL be treated as a new request, subject to round-robin.
REQ-021 Operands SHALL be sampled only in the IDLE grant cycle; later changes to a_in/b_in SHALL NOT affect the product in flight.
REQ-022 A zero operand SHALL yield result 0 through the same ISSUE/WAIT_MULT/DELIVER sequence.
REQ-023 result SHALL equal the unsigned WIDTH x WIDTH product, full 2*WIDTH bits, with no truncation.
REQ-024 When ack is zero, result and result_id SHALL be 0.
REQ-025 Minimum latency from grant to ack SHALL be 3 cycles plus the multiplier's busy time.
REQ-026 A requester dropping req before its ack is a protocol violation, and the block SHALL still complete and ack that operation.

Reset
REQ-027 rst SHALL immediately force: FSM to IDLE, rr_ptr=0, ack=0, result=0, result_id=0, busy=0, latched operands=0, multiplier start=0.
REQ-028 rst asserted mid-operation SHALL abandon the operation without an ack; the multiplier instance SHALL receive the same rst.
REQ-029 After rst deasserts, the first grant SHALL go to the lowest-index active requester.

Structure
REQ-030 The FSM state enum and the default NUM_REQ/WIDTH constants SHALL live in the shared package mult_pkg.
REQ-031 The block SHALL contain exactly one sub-module instance, asmd_mult, the shared sequential multiplier (start/ready/r handshake).
REQ-032 Arbitration, operand latching and the FSM SHALL be in mult_arbiter itself, with no further hierarchy.

Verification
REQ-033 req=0001, a0=3, b0=5 -> ack=0001 once, result=15, result_id=0, busy low afterwards.
REQ-034 req=1111 held, operands i+1 x 2 -> acks in order 0,1,2,3,0..., results 2,4,6,8, each ack one cycle.
REQ-035 req=0010, a1=0, b1=9 -> ack=0010, result=0.
REQ-036 req=0100, a2=255, b2=255 -> result=65025, result_id=2.
REQ-037 rst pulsed during WAIT_MULT with req0 pending -> no ack, all outputs 0, and after release req0 completes correctly.
REQ-038 a1 changed from 7 to 100 one cycle after grant, b1=6 -> result=42.
